// File: rtl/raw3270_pkg.sv
// Shared constants and state encoding for the 3270 raw serial transmitter.
package raw3270_pkg;

    localparam int unsigned WORD_W            = 12;
    localparam int unsigned HDR_SLOTS         = 16;
    localparam int unsigned DATA_SLOTS        = 2 * WORD_W;
    localparam int unsigned END_SLOTS         = 2;
    localparam int unsigned SLOT_CNT_W        = 5;
    localparam int unsigned HALF_BIT_CLKS_DEF = 18;
    localparam logic [HDR_SLOTS-1:0] HEADER_DEF = 16'b0101010101000111;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HEADER = 2'd1,
        ST_DATA   = 2'd2,
        ST_END    = 2'd3
    } tx_state_e;

endpackage

// File: rtl/raw3270_bit_timer.sv
// Half-bit slot timer: reloads while idle, strobes on the last cycle of each slot.
module raw3270_bit_timer #(
    parameter int unsigned HALF_BIT_CLKS = 18
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run_i,
    output logic slot_end_c
);

    localparam int unsigned CNT_W = $clog2(HALF_BIT_CLKS);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = CNT_W'(HALF_BIT_CLKS - 1);
        if (run_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    assign slot_end_c = run_i && (cnt_q == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/raw3270_transmitter.sv
// Frames 12-bit words as header, complementary half-bit data pairs and a 1,1 terminator.
module raw3270_transmitter
    import raw3270_pkg::*;
#(
    parameter logic [15:0] HEADER        = HEADER_DEF,
    parameter int unsigned HALF_BIT_CLKS = HALF_BIT_CLKS_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [WORD_W-1:0] txWord,
    input  logic              txValid,
    input  logic              txLast,
    output logic              txReady,
    output logic              serialOut,
    output logic              busy,
    output logic              underrun
);

    tx_state_e             state_q, state_d;
    logic [SLOT_CNT_W-1:0] slot_q, slot_d;
    logic [WORD_W-1:0]     shift_q, shift_d;
    logic                  last_q, last_d;
    logic [WORD_W-1:0]     hold_word_q, hold_word_d;
    logic                  hold_last_q, hold_last_d;
    logic                  hold_full_q, hold_full_d;
    logic                  serial_q, busy_q, und_pend_q, underrun_q;

    logic                  slot_end;
    logic                  accept;
    logic                  word_start;
    logic                  abort;
    logic                  line_bit;
    logic [3:0]            hdr_idx;

    raw3270_bit_timer #(
        .HALF_BIT_CLKS (HALF_BIT_CLKS)
    ) u_bit_timer (
        .clk        (clk),
        .rst_n      (reset),
        .run_i      (state_q != ST_IDLE),
        .slot_end_c (slot_end)
    );

    assign txReady   = ~hold_full_q;
    assign accept    = txValid && ~hold_full_q;
    assign hdr_idx   = 4'(HDR_SLOTS - 1) - slot_q[3:0];
    assign serialOut = serial_q;
    assign busy      = busy_q;
    assign underrun  = underrun_q;

    // Frame sequencer: slot counting, word hand-off and line level selection.
    always_comb begin
        state_d    = state_q;
        slot_d     = slot_q;
        shift_d    = shift_q;
        last_d     = last_q;
        word_start = 1'b0;
        abort      = 1'b0;
        line_bit   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (hold_full_q) begin
                    state_d = ST_HEADER;
                    slot_d  = '0;
                end
            end
            ST_HEADER: begin
                line_bit = HEADER[hdr_idx];
                if (slot_end) begin
                    if (slot_q == SLOT_CNT_W'(HDR_SLOTS - 1)) begin
                        state_d    = ST_DATA;
                        slot_d     = '0;
                        word_start = 1'b1;
                    end else begin
                        slot_d = slot_q + SLOT_CNT_W'(1);
                    end
                end
            end
            ST_DATA: begin
                // Even slot carries the complement, odd slot the true bit.
                line_bit = slot_q[0] ? shift_q[WORD_W-1] : ~shift_q[WORD_W-1];
                if (slot_end) begin
                    slot_d = slot_q + SLOT_CNT_W'(1);
                    if (slot_q[0]) begin
                        shift_d = {shift_q[WORD_W-2:0], 1'b0};
                    end
                    if (slot_q == SLOT_CNT_W'(DATA_SLOTS - 1)) begin
                        slot_d = '0;
                        if (last_q) begin
                            state_d = ST_END;
                        end else if (hold_full_q) begin
                            word_start = 1'b1;
                        end else begin
                            state_d = ST_END;
                            abort   = 1'b1;
                        end
                    end
                end
            end
            ST_END: begin
                line_bit = 1'b1;
                if (slot_end) begin
                    if (slot_q == SLOT_CNT_W'(END_SLOTS - 1)) begin
                        state_d = ST_IDLE;
                        slot_d  = '0;
                    end else begin
                        slot_d = slot_q + SLOT_CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (word_start) begin
            shift_d = hold_word_q;
            last_d  = hold_last_q;
        end
    end

    // Single-entry holding register between the producer and the shifter.
    always_comb begin
        hold_full_d = hold_full_q;
        hold_word_d = hold_word_q;
        hold_last_d = hold_last_q;
        if (word_start) begin
            hold_full_d = 1'b0;
        end
        if (accept) begin
            hold_full_d = 1'b1;
            hold_word_d = txWord;
            hold_last_d = txLast;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            slot_q      <= '0;
            shift_q     <= '0;
            last_q      <= 1'b0;
            hold_word_q <= '0;
            hold_last_q <= 1'b0;
            hold_full_q <= 1'b0;
            serial_q    <= 1'b0;
            busy_q      <= 1'b0;
            und_pend_q  <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            slot_q      <= slot_d;
            shift_q     <= shift_d;
            last_q      <= last_d;
            hold_word_q <= hold_word_d;
            hold_last_q <= hold_last_d;
            hold_full_q <= hold_full_d;
            serial_q    <= line_bit;
            busy_q      <= (state_q != ST_IDLE);
            // Delayed one cycle so the pulse lines up with the first terminator slot on the line.
            und_pend_q  <= abort;
            underrun_q  <= und_pend_q;
        end
    end

endmodule
